// File: rtl/cnn_accel_pkg.sv
// Shared constants for the CNN accelerator MMIO master: bus width, command ops, FSM states.
package cnn_accel_pkg;

  localparam int MMIO_W = 32;

  typedef enum logic [1:0] {
    OP_WRITE     = 2'b00,
    OP_READ      = 2'b01,
    OP_WAIT_INTR = 2'b10,
    OP_RSVD      = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ      = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_WAIT_INTR = 3'd4,
    ST_RESP      = 3'd5
  } state_t;

endpackage

// File: rtl/cnn_accel_mmio_master_if.sv
// Command/response handshake plus accelerator MMIO signals; master is the DUT side.
interface cnn_accel_mmio_master_if;
  import cnn_accel_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [MMIO_W-1:0] cmd_addr;
  logic [MMIO_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [MMIO_W-1:0] rsp_data;
  logic              rsp_timeout;
  logic              mmio_write_en;
  logic              mmio_read_en;
  logic [MMIO_W-1:0] mmio_addr;
  logic [MMIO_W-1:0] mmio_wdata;
  logic [MMIO_W-1:0] mmio_rdata;
  logic              intr;
  logic              busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, mmio_rdata, intr,
    output cmd_ready, rsp_valid, rsp_data, rsp_timeout,
           mmio_write_en, mmio_read_en, mmio_addr, mmio_wdata, busy
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, mmio_rdata, intr,
    input  cmd_ready, rsp_valid, rsp_data, rsp_timeout,
           mmio_write_en, mmio_read_en, mmio_addr, mmio_wdata, busy
  );

endinterface

// File: rtl/cnn_accel_cycle_ctr.sv
// Up-counter shared by read-latency and interrupt-timeout waits; done is combinational on count==terminal.
module cnn_accel_cycle_ctr #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] terminal,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  assign done = (count == terminal);

endmodule

// File: rtl/cnn_accel_mmio_master.sv
// One-command-in-flight MMIO master: write strobe N+1, read response N+2+READ_LAT, intr wait with timeout.
// Response holds until rsp_ready; commands are only accepted in IDLE.
module cnn_accel_mmio_master
  import cnn_accel_pkg::*;
#(
  parameter int READ_LAT       = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  cnn_accel_mmio_master_if.master bus
);

  localparam int CTR_W = 21;

  state_t            state, state_nxt;
  logic              accept;
  logic              cap_rsp;
  logic [MMIO_W-1:0] rsp_data_nxt;
  logic              rsp_to_nxt;
  logic              ctr_en;
  logic              ctr_done;
  logic [CTR_W-1:0]  ctr_term;
  logic [MMIO_W-1:0] addr_q, wdata_q, rsp_data_q;
  logic              rsp_to_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    cap_rsp      = 1'b0;
    rsp_data_nxt = '0;
    rsp_to_nxt   = 1'b0;
    ctr_en       = 1'b0;
    ctr_term     = CTR_W'(READ_LAT - 1);
    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid && !reset) begin
          accept = 1'b1;
          case (op_t'(bus.cmd_op))
            OP_WRITE:     state_nxt = ST_WRITE;
            OP_READ:      state_nxt = ST_READ;
            OP_WAIT_INTR: state_nxt = ST_WAIT_INTR;
            default:      state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_WRITE: state_nxt = ST_IDLE;
      ST_READ:  state_nxt = ST_READ_WAIT;
      ST_READ_WAIT: begin
        ctr_en = 1'b1;
        if (ctr_done) begin
          cap_rsp      = 1'b1;
          rsp_data_nxt = bus.mmio_rdata;
          state_nxt    = ST_RESP;
        end
      end
      ST_WAIT_INTR: begin
        ctr_en   = 1'b1;
        ctr_term = CTR_W'(TIMEOUT_CYCLES - 1);
        // intr takes priority over an expiry in the same cycle
        if (bus.intr) begin
          cap_rsp   = 1'b1;
          state_nxt = ST_RESP;
        end else if (ctr_done) begin
          cap_rsp    = 1'b1;
          rsp_to_nxt = 1'b1;
          state_nxt  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  cnn_accel_cycle_ctr #(.W(CTR_W)) u_ctr (
    .clk      (clk),
    .reset    (reset),
    .clear    (!ctr_en),
    .enable   (ctr_en),
    .terminal (ctr_term),
    .done     (ctr_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_to_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= bus.cmd_addr;
        wdata_q <= bus.cmd_wdata;
      end
      if (cap_rsp) begin
        rsp_data_q <= rsp_data_nxt;
        rsp_to_q   <= rsp_to_nxt;
      end
    end
  end

  assign bus.cmd_ready     = (state == ST_IDLE) && !reset;
  assign bus.busy          = (state != ST_IDLE);
  assign bus.mmio_write_en = (state == ST_WRITE);
  assign bus.mmio_read_en  = (state == ST_READ);
  assign bus.rsp_valid     = (state == ST_RESP);
  assign bus.mmio_addr     = addr_q;
  assign bus.mmio_wdata    = wdata_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_timeout   = rsp_to_q;

endmodule

// File: tb/tb_cnn_accel_mmio_master.sv
// Directed bench for cnn_accel_mmio_master with READ_LAT=1, TIMEOUT_CYCLES=16 and a one-cycle read model.
module tb_cnn_accel_mmio_master;
  import cnn_accel_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  cnn_accel_mmio_master_if bus ();

  cnn_accel_mmio_master #(.READ_LAT(1), .TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return (a == 32'h14) ? 32'h1234_5678 : (a ^ 32'hA5A5_0000);
  endfunction

  // Read data is valid only in the cycle after the strobe
  always @(posedge clk)
    bus.mmio_rdata <= bus.mmio_read_en ? model_rd(bus.mmio_addr) : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
    chk("cmd_ready_before_send", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bus.rsp_ready = 1'b1;
    step();
    chk("rsp_valid_after_handshake", 32'(bus.rsp_valid), 32'd0);
    chk("busy_after_handshake", 32'(bus.busy), 32'd0);
    bus.rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_t;

  initial begin
    cmd_t        stream [4];
    logic [31:0] rsp_d [$];
    logic        rsp_t [$];
    int          idx, we_cnt, re_cnt;
    logic        acc;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.intr      = 1'b0;

    // Reset values
    repeat (2) step();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_write_en", 32'(bus.mmio_write_en), 32'd0);
    chk("rst_read_en", 32'(bus.mmio_read_en), 32'd0);
    chk("rst_mmio_addr", bus.mmio_addr, 32'd0);
    chk("rst_mmio_wdata", bus.mmio_wdata, 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    reset = 1'b0;
    step();
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Single WRITE
    send(OP_WRITE, 32'h10, 32'hDEAD_BEEF);
    chk("wr_write_en", 32'(bus.mmio_write_en), 32'd1);
    chk("wr_read_en", 32'(bus.mmio_read_en), 32'd0);
    chk("wr_addr", bus.mmio_addr, 32'h10);
    chk("wr_wdata", bus.mmio_wdata, 32'hDEAD_BEEF);
    chk("wr_busy", 32'(bus.busy), 32'd1);
    chk("wr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("wr_strobe_one_cycle", 32'(bus.mmio_write_en), 32'd0);
    chk("wr_no_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("wr_addr_hold", bus.mmio_addr, 32'h10);

    // Back-to-back writes, one every 2 cycles
    for (int i = 0; i < 3; i++) begin
      send(OP_WRITE, 32'h20 + 32'(4 * i), 32'(i + 7));
      chk("b2b_write_en", 32'(bus.mmio_write_en), 32'd1);
      chk("b2b_wdata", bus.mmio_wdata, 32'(i + 7));
      step();
    end

    // READ with stall on rsp_ready
    send(OP_READ, 32'h14, 32'h0);
    chk("rd_read_en", 32'(bus.mmio_read_en), 32'd1);
    chk("rd_write_en", 32'(bus.mmio_write_en), 32'd0);
    chk("rd_addr", bus.mmio_addr, 32'h14);
    step();
    chk("rd_strobe_one_cycle", 32'(bus.mmio_read_en), 32'd0);
    chk("rd_rsp_not_yet", 32'(bus.rsp_valid), 32'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("rd_rsp_valid_hold", 32'(bus.rsp_valid), 32'd1);
      chk("rd_rsp_data_hold", bus.rsp_data, 32'h1234_5678);
      chk("rd_rsp_timeout_hold", 32'(bus.rsp_timeout), 32'd0);
      chk("rd_cmd_ready_blocked", 32'(bus.cmd_ready), 32'd0);
      step();
    end
    drain();

    // WAIT_INTR, intr raised 10 cycles after entry
    send(OP_WAIT_INTR, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      chk("wi_pending", 32'(bus.rsp_valid), 32'd0);
      chk("wi_busy", 32'(bus.busy), 32'd1);
      step();
    end
    bus.intr = 1'b1;
    chk("wi_pending_intr_cycle", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("wi_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("wi_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    chk("wi_rsp_data", bus.rsp_data, 32'd0);
    bus.intr = 1'b0;
    drain();

    // intr already high on entry: one WAIT_INTR cycle
    bus.intr = 1'b1;
    send(OP_WAIT_INTR, 32'h0, 32'h0);
    chk("wi_entry_pending", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("wi_entry_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("wi_entry_timeout", 32'(bus.rsp_timeout), 32'd0);
    bus.intr = 1'b0;
    drain();

    // Timeout after 16 WAIT_INTR cycles
    send(OP_WAIT_INTR, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      chk("to_pending", 32'(bus.rsp_valid), 32'd0);
      step();
    end
    chk("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("to_rsp_timeout", 32'(bus.rsp_timeout), 32'd1);
    chk("to_rsp_data", bus.rsp_data, 32'd0);
    drain();

    // intr on the final count cycle wins
    send(OP_WAIT_INTR, 32'h0, 32'h0);
    for (int i = 0; i < 15; i++) begin
      chk("last_pending", 32'(bus.rsp_valid), 32'd0);
      step();
    end
    bus.intr = 1'b1;
    step();
    chk("last_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("last_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    bus.intr = 1'b0;
    drain();

    // Reset in READ_WAIT
    send(OP_READ, 32'h30, 32'h55);
    step();
    reset = 1'b1;
    step();
    chk("rst_rw_busy", 32'(bus.busy), 32'd0);
    chk("rst_rw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rw_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_rw_addr", bus.mmio_addr, 32'd0);
    chk("rst_rw_wdata", bus.mmio_wdata, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_rw_no_stale", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rw_idle", 32'(bus.busy), 32'd0);
    end

    // Reset with a pending response
    send(OP_READ, 32'h14, 32'h66);
    step();
    step();
    chk("rst_resp_pre_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rst_resp_pre_data", bus.rsp_data, 32'h1234_5678);
    reset = 1'b1;
    step();
    chk("rst_resp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_resp_data", bus.rsp_data, 32'd0);
    chk("rst_resp_busy", 32'(bus.busy), 32'd0);
    chk("rst_resp_addr", bus.mmio_addr, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_resp_no_stale", 32'(bus.rsp_valid), 32'd0);
    end

    // Interleaved stream: WRITE, reserved, READ, WAIT_INTR
    stream[0] = '{OP_WRITE,     32'h40, 32'h1111_2222};
    stream[1] = '{OP_RSVD,      32'h48, 32'h0};
    stream[2] = '{OP_READ,      32'h44, 32'h0};
    stream[3] = '{OP_WAIT_INTR, 32'h0,  32'h0};
    idx = 0;
    we_cnt = 0;
    re_cnt = 0;
    bus.intr      = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = stream[0].op;
    bus.cmd_addr  = stream[0].addr;
    bus.cmd_wdata = stream[0].data;
    for (int c = 0; c < 20; c++) begin
      chk("mix_no_overlap", 32'(bus.mmio_write_en && bus.mmio_read_en), 32'd0);
      chk("mix_busy_vs_idle", 32'(bus.busy), 32'(!bus.cmd_ready));
      if (bus.mmio_write_en) we_cnt++;
      if (bus.mmio_read_en) re_cnt++;
      if (bus.rsp_valid) begin
        rsp_d.push_back(bus.rsp_data);
        rsp_t.push_back(bus.rsp_timeout);
      end
      acc = bus.cmd_valid && bus.cmd_ready;
      step();
      if (acc) begin
        idx++;
        if (idx < 4) begin
          bus.cmd_op    = stream[idx].op;
          bus.cmd_addr  = stream[idx].addr;
          bus.cmd_wdata = stream[idx].data;
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
    end
    bus.intr      = 1'b0;
    bus.rsp_ready = 1'b0;
    chk("mix_all_accepted", 32'(idx), 32'd4);
    chk("mix_write_strobes", 32'(we_cnt), 32'd1);
    chk("mix_read_strobes", 32'(re_cnt), 32'd1);
    chk("mix_rsp_count", 32'(rsp_d.size()), 32'd2);
    if (rsp_d.size() == 2) begin
      chk("mix_rsp0_data", rsp_d[0], 32'hA5A5_0044);
      chk("mix_rsp0_timeout", 32'(rsp_t[0]), 32'd0);
      chk("mix_rsp1_data", rsp_d[1], 32'd0);
      chk("mix_rsp1_timeout", 32'(rsp_t[1]), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
